// File: rtl/sram_responder.sv
// Memory-side responder for the SLC-3 async SRAM pin bus: DEPTH x 16 array, byte lanes, read/write wait states.
// Optional macro SRAM_BOOT_CLEAR_EN adds a CLEAR state that zeroes the array after reset.
module sram_responder #(
  parameter int AW        = 10,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        UB,
  input  logic        LB,
  input  logic        OE,
  input  logic        WE,
  input  logic [19:0] ADDR,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic        Data_oe,
  output logic        Ready,
  output logic        Busy
);
  localparam int         DEPTH     = 2 ** AW;
  localparam logic [3:0] RD_RELOAD = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_RELOAD = 4'(WRITE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_HOLD
`ifdef SRAM_BOOT_CLEAR_EN
    , CLEAR
`endif
  } state_t;

`ifdef SRAM_BOOT_CLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t      r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic [19:0] r_addr, w_addr_nx;
  logic [15:0] r_data_out, w_dout_nx;
  logic        r_hold_first, w_hold_nx;
  logic        w_commit, w_clear_we;
  logic [15:0] r_mem [DEPTH];

  logic        w_rd_req, w_wr_req, w_addr_chg, w_rd_in_range, w_wr_in_range;
  logic [15:0] w_mem_rdata, w_rd_word, w_wdata;
  logic [AW-1:0] w_waddr;
  logic        w_we_hi, w_we_lo;

  assign w_rd_req      = ~CE & ~OE & WE;
  assign w_wr_req      = ~CE & ~WE;
  assign w_addr_chg    = (ADDR != r_addr);
  assign w_rd_in_range = (ADDR[19:AW] == '0);
  assign w_wr_in_range = (r_addr[19:AW] == '0);

  // The read port follows the live address; it only matters when ADDR equals the captured one.
  assign w_mem_rdata = r_mem[ADDR[AW-1:0]];
  assign w_rd_word   = w_rd_in_range ? {UB ? 8'h00 : w_mem_rdata[15:8],
                                        LB ? 8'h00 : w_mem_rdata[7:0]} : 16'h0000;

`ifdef SRAM_BOOT_CLEAR_EN
  logic [AW-1:0] r_sweep, w_sweep_nx;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_addr_nx  = r_addr;
    w_dout_nx  = r_data_out;
    w_hold_nx  = 1'b0;
    w_commit   = 1'b0;
    w_clear_we = 1'b0;
`ifdef SRAM_BOOT_CLEAR_EN
    w_sweep_nx = r_sweep;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_wr_req) begin
          w_addr_nx  = ADDR;
          w_cnt_nx   = WR_RELOAD;
          w_state_nx = WR_WAIT;
        end else if (w_rd_req) begin
          w_addr_nx = ADDR;
          w_cnt_nx  = RD_RELOAD;
          if (READ_LAT == 1) begin
            w_state_nx = RD_DRIVE;
            w_dout_nx  = w_rd_word;
          end else begin
            w_state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (w_wr_req) begin
          w_addr_nx  = ADDR;
          w_cnt_nx   = WR_RELOAD;
          w_state_nx = WR_WAIT;
        end else if (!w_rd_req) begin
          w_state_nx = IDLE;
        end else if (w_addr_chg) begin
          w_addr_nx = ADDR;
          w_cnt_nx  = RD_RELOAD;
        end else if (r_cnt <= 4'd1) begin
          // Data is loaded on the edge entering RD_DRIVE, giving READ_LAT edges end to end.
          w_state_nx = RD_DRIVE;
          w_dout_nx  = w_rd_word;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      RD_DRIVE: begin
        if (w_wr_req) begin
          w_addr_nx  = ADDR;
          w_cnt_nx   = WR_RELOAD;
          w_state_nx = WR_WAIT;
        end else if (!w_rd_req) begin
          w_state_nx = IDLE;
        end else if (w_addr_chg) begin
          w_addr_nx  = ADDR;
          w_cnt_nx   = RD_RELOAD;
          w_state_nx = RD_WAIT;
        end else begin
          w_dout_nx = w_rd_word;
        end
      end
      WR_WAIT: begin
        if (!w_wr_req) begin
          w_state_nx = IDLE;
        end else if (r_cnt == 4'd0) begin
          w_commit   = 1'b1;
          w_hold_nx  = 1'b1;
          w_state_nx = WR_HOLD;
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
        end
      end
      WR_HOLD: begin
        if (!w_wr_req) w_state_nx = IDLE;
      end
`ifdef SRAM_BOOT_CLEAR_EN
      CLEAR: begin
        w_clear_we = 1'b1;
        w_sweep_nx = r_sweep + 1'b1;
        if (r_sweep == {AW{1'b1}}) w_state_nx = IDLE;
      end
`endif
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= RESET_STATE;
      r_cnt        <= 4'd0;
      r_addr       <= 20'h0;
      r_data_out   <= 16'h0000;
      r_hold_first <= 1'b0;
`ifdef SRAM_BOOT_CLEAR_EN
      r_sweep      <= '0;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_addr       <= w_addr_nx;
      r_data_out   <= w_dout_nx;
      r_hold_first <= w_hold_nx;
`ifdef SRAM_BOOT_CLEAR_EN
      r_sweep      <= w_sweep_nx;
`endif
    end
  end

`ifdef SRAM_BOOT_CLEAR_EN
  assign w_waddr = w_clear_we ? r_sweep : r_addr[AW-1:0];
`else
  assign w_waddr = r_addr[AW-1:0];
`endif
  assign w_wdata = w_clear_we ? 16'h0000 : Data_in;
  assign w_we_hi = w_clear_we | (w_commit & w_wr_in_range & ~UB);
  assign w_we_lo = w_clear_we | (w_commit & w_wr_in_range & ~LB);

  // NOTE: the array has no reset so it maps onto RAM; only the optional sweep clears it.
  always_ff @(posedge Clk) begin
    if (w_we_hi) r_mem[w_waddr][15:8] <= w_wdata[15:8];
    if (w_we_lo) r_mem[w_waddr][7:0]  <= w_wdata[7:0];
  end

  assign Data_out = r_data_out;
  assign Data_oe  = (r_state == RD_DRIVE) & ~CE & ~OE & WE;
  assign Ready    = (r_state == RD_DRIVE) | r_hold_first;
  assign Busy     = (r_state != IDLE);
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: instance a uses default latencies, instance b uses WRITE_LAT=3.
module tb_sram_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, ce, ub, lb, oe, we;
  logic [19:0] addr;
  logic [15:0] din;
  logic [15:0] a_dout, b_dout;
  logic        a_oe, a_rdy, a_busy, b_oe, b_rdy, b_busy;
  int          checks = 0;
  int          failures = 0;

`ifdef SRAM_BOOT_CLEAR_EN
  localparam logic       EXP_RST_BUSY = 1'b1;
  localparam logic [15:0] EXP_KEEP    = 16'h0000;
`else
  localparam logic       EXP_RST_BUSY = 1'b0;
  localparam logic [15:0] EXP_KEEP    = 16'h0CAF;
`endif

  sram_responder #(.AW(10), .READ_LAT(2), .WRITE_LAT(1)) dut_a (
    .Clk(clk), .Reset(rst_a), .CE(ce), .UB(ub), .LB(lb), .OE(oe), .WE(we),
    .ADDR(addr), .Data_in(din), .Data_out(a_dout), .Data_oe(a_oe),
    .Ready(a_rdy), .Busy(a_busy));

  sram_responder #(.AW(10), .READ_LAT(2), .WRITE_LAT(3)) dut_b (
    .Clk(clk), .Reset(rst_b), .CE(ce), .UB(ub), .LB(lb), .OE(oe), .WE(we),
    .ADDR(addr), .Data_in(din), .Data_out(b_dout), .Data_oe(b_oe),
    .Ready(b_rdy), .Busy(b_busy));

  task automatic bus_idle();
    ce = 1'b1; oe = 1'b1; we = 1'b1; ub = 1'b1; lb = 1'b1;
  endtask

  // Holds WE low long enough for both instances to commit, then releases the bus.
  task automatic write_word(input logic [19:0] a, input logic [15:0] d,
                            input logic ub_n, input logic lb_n);
    @(negedge clk);
    ce = 1'b0; we = 1'b0; oe = 1'b1; addr = a; din = d; ub = ub_n; lb = lb_n;
    repeat (5) @(negedge clk);
    bus_idle();
  endtask

  task automatic read_word(input logic [19:0] a, input logic ub_n, input logic lb_n,
                           output logic oe_first, output logic oe_a, output logic rdy_a,
                           output logic [15:0] da, output logic [15:0] db);
    @(negedge clk);
    ce = 1'b0; oe = 1'b0; we = 1'b1; addr = a; ub = ub_n; lb = lb_n;
    @(negedge clk);
    oe_first = a_oe;
    @(negedge clk);
    oe_a = a_oe; rdy_a = a_rdy; da = a_dout; db = b_dout;
    bus_idle();
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; addr = 20'h0; din = 16'h0;
    bus_idle();
    repeat (2) @(negedge clk);
    checks++; if (a_dout !== 16'h0000) begin failures++; $display("FAIL rst_dout: got %h exp 0000", a_dout); end
    checks++; if (a_oe !== 1'b0) begin failures++; $display("FAIL rst_oe: got %b exp 0", a_oe); end
    checks++; if (a_rdy !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b exp 0", a_rdy); end
    checks++; if (a_busy !== EXP_RST_BUSY) begin failures++; $display("FAIL rst_busy: got %b exp %b", a_busy, EXP_RST_BUSY); end
    rst_a = 1'b0; rst_b = 1'b0;
`ifdef SRAM_BOOT_CLEAR_EN
    begin
      int n;
      logic o1, o2, r;
      logic [15:0] da, db;
      n = 0;
      while (a_busy === 1'b1 && n < 2000) begin
        @(posedge clk); #1; n++;
      end
      checks++; if (n != 1024) begin failures++; $display("FAIL clear_busy_cycles: got %0d exp 1024", n); end
      read_word(20'h00005, 1'b0, 1'b0, o1, o2, r, da, db);
      checks++; if (da !== 16'h0000) begin failures++; $display("FAIL clear_rd_005: got %h exp 0000", da); end
      read_word(20'h003FF, 1'b0, 1'b0, o1, o2, r, da, db);
      checks++; if (da !== 16'h0000) begin failures++; $display("FAIL clear_rd_3ff: got %h exp 0000", da); end
    end
`endif
  endtask

  task automatic test_basic_read();
    logic o1, o2, r;
    logic [15:0] da, db;
    write_word(20'h00005, 16'hBEEF, 1'b0, 1'b0);
    read_word(20'h00005, 1'b0, 1'b0, o1, o2, r, da, db);
    checks++; if (o1 !== 1'b0) begin failures++; $display("FAIL rd_oe_edge1: got %b exp 0", o1); end
    checks++; if (o2 !== 1'b1) begin failures++; $display("FAIL rd_oe_edge2: got %b exp 1", o2); end
    checks++; if (r !== 1'b1) begin failures++; $display("FAIL rd_ready: got %b exp 1", r); end
    checks++; if (da !== 16'hBEEF) begin failures++; $display("FAIL rd_data: got %h exp BEEF", da); end
  endtask

  task automatic test_byte_lanes();
    logic o1, o2, r;
    logic [15:0] da, db;
    write_word(20'h00010, 16'h1234, 1'b0, 1'b0);
    write_word(20'h00010, 16'hAB00, 1'b0, 1'b1);
    read_word(20'h00010, 1'b0, 1'b0, o1, o2, r, da, db);
    checks++; if (da !== 16'hAB34) begin failures++; $display("FAIL lane_both: got %h exp AB34", da); end
    read_word(20'h00010, 1'b1, 1'b0, o1, o2, r, da, db);
    checks++; if (da !== 16'h0034) begin failures++; $display("FAIL lane_ub_masked: got %h exp 0034", da); end
    read_word(20'h00010, 1'b0, 1'b1, o1, o2, r, da, db);
    checks++; if (da !== 16'hAB00) begin failures++; $display("FAIL lane_lb_masked: got %h exp AB00", da); end
  endtask

  task automatic test_out_of_range();
    logic o1, o2, r;
    logic [15:0] da, db;
    write_word(20'h00000, 16'h5A5A, 1'b0, 1'b0);
    write_word(20'h003FF, 16'hC3C3, 1'b0, 1'b0);
    write_word(20'h00400, 16'hFFFF, 1'b0, 1'b0);
    read_word(20'h00000, 1'b0, 1'b0, o1, o2, r, da, db);
    checks++; if (da !== 16'h5A5A) begin failures++; $display("FAIL oor_alias_000: got %h exp 5A5A", da); end
    read_word(20'h003FF, 1'b0, 1'b0, o1, o2, r, da, db);
    checks++; if (da !== 16'hC3C3) begin failures++; $display("FAIL top_word_3ff: got %h exp C3C3", da); end
    read_word(20'h00400, 1'b0, 1'b0, o1, o2, r, da, db);
    checks++; if (da !== 16'h0000) begin failures++; $display("FAIL oor_read_400: got %h exp 0000", da); end
  endtask

  task automatic test_addr_change();
    @(negedge clk);
    ce = 1'b0; oe = 1'b0; we = 1'b1; ub = 1'b0; lb = 1'b0; addr = 20'h00005;
    repeat (2) @(negedge clk);
    checks++; if (a_dout !== 16'hBEEF) begin failures++; $display("FAIL chg_first: got %h exp BEEF", a_dout); end
    addr = 20'h00010;
    @(negedge clk);
    checks++; if (a_rdy !== 1'b0) begin failures++; $display("FAIL chg_ready_drop: got %b exp 0", a_rdy); end
    checks++; if (a_oe !== 1'b0) begin failures++; $display("FAIL chg_oe_drop: got %b exp 0", a_oe); end
    @(negedge clk);
    checks++; if (a_dout !== 16'hAB34) begin failures++; $display("FAIL chg_second: got %h exp AB34", a_dout); end
    checks++; if (a_rdy !== 1'b1) begin failures++; $display("FAIL chg_ready_back: got %b exp 1", a_rdy); end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic o1, o2, r;
    logic [15:0] da, db;
    int pulses;
    write_word(20'h00020, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    ce = 1'b0; oe = 1'b0; we = 1'b1; ub = 1'b0; lb = 1'b0; addr = 20'h00020;
    repeat (2) @(negedge clk);
    checks++; if (a_oe !== 1'b1) begin failures++; $display("FAIL abort_oe_before: got %b exp 1", a_oe); end
    checks++; if (a_dout !== 16'h1111) begin failures++; $display("FAIL abort_rd_data: got %h exp 1111", a_dout); end
    we = 1'b0; din = 16'h2222;
    #1;
    checks++; if (a_oe !== 1'b0) begin failures++; $display("FAIL abort_oe_same_cycle: got %b exp 0", a_oe); end
    @(negedge clk);
    checks++; if (a_rdy !== 1'b0) begin failures++; $display("FAIL wr_ready_early: got %b exp 0", a_rdy); end
    @(negedge clk);
    checks++; if (a_rdy !== 1'b1) begin failures++; $display("FAIL wr_ready_pulse: got %b exp 1", a_rdy); end
    din = 16'h3333;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_rdy === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL wr_ready_extra: got %0d exp 0", pulses); end
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL wr_hold_busy: got %b exp 1", a_busy); end
    bus_idle();
    read_word(20'h00020, 1'b0, 1'b0, o1, o2, r, da, db);
    checks++; if (da !== 16'h2222) begin failures++; $display("FAIL single_commit: got %h exp 2222", da); end
  endtask

  task automatic test_reset_mid_write();
    logic o1, o2, r;
    logic [15:0] da, db;
    int n;
    write_word(20'h00030, 16'h0CAF, 1'b0, 1'b0);
    read_word(20'h00030, 1'b0, 1'b0, o1, o2, r, da, db);
    checks++; if (db !== 16'h0CAF) begin failures++; $display("FAIL b_preload: got %h exp 0CAF", db); end
    @(negedge clk);
    ce = 1'b0; we = 1'b0; oe = 1'b1; ub = 1'b0; lb = 1'b0; addr = 20'h00030; din = 16'hDEAD;
    repeat (2) @(negedge clk);
    checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL b_wr_wait_busy: got %b exp 1", b_busy); end
    rst_b = 1'b1;
    #1;
    checks++; if (b_dout !== 16'h0000) begin failures++; $display("FAIL b_rst_dout: got %h exp 0000", b_dout); end
    checks++; if (b_rdy !== 1'b0) begin failures++; $display("FAIL b_rst_ready: got %b exp 0", b_rdy); end
    checks++; if (b_busy !== EXP_RST_BUSY) begin failures++; $display("FAIL b_rst_busy: got %b exp %b", b_busy, EXP_RST_BUSY); end
    @(negedge clk);
    rst_b = 1'b0;
    bus_idle();
    n = 0;
    while (b_busy === 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL b_idle_timeout: got %b exp 0", b_busy); end
    read_word(20'h00030, 1'b0, 1'b0, o1, o2, r, da, db);
    checks++; if (db !== EXP_KEEP) begin failures++; $display("FAIL b_word_kept: got %h exp %h", db, EXP_KEEP); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_byte_lanes();
    test_out_of_range();
    test_addr_change();
    test_back_to_back();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
